pellet_map_ram: RTL and testbench



---
 rtl/pellet_map_ram.sv | 121 ++++++++++++
 tb/tb_pellet_map_ram.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_map_ram.sv
// Writable per-tile pellet map: self-loads from the wall ROM on reset/restart,
// then serves NRD registered read ports and single-tile eat updates.
module pellet_map_ram #(
    parameter int COLS   = 32,
    parameter int ROWS   = 24,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = $clog2(ROWS*COLS+1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    output logic [ADDR_W-1:0]        wall_addr,
    input  logic [COLS-1:0]          wall_data,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*COLS-1:0]      rd_data,
    input  logic                     eat_valid,
    input  logic [ADDR_W-1:0]        eat_row,
    input  logic [$clog2(COLS)-1:0]  eat_col,
    output logic                     eat_hit,
    output logic [CNT_W-1:0]         pellets_left,
    output logic                     ready,
    output logic                     all_eaten
);

    typedef enum logic {LOAD, READY} state_t;

    localparam logic [ADDR_W:0]   ROWS_X   = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS-1);

    state_t state_q, state_d;

    logic [COLS-1:0]   mem [ROWS];
    logic [ADDR_W:0]   iss;
    logic [ADDR_W-1:0] wr;
    logic              wr_valid;
    logic              issuing;
    logic              storing;
    logic              eat_ok;
    logic [CNT_W-1:0]  wall_cnt;
    logic [CNT_W-1:0]  row_pellets;
    logic [ADDR_W-1:0] rd_row [NRD];

    assign issuing   = (state_q == LOAD) && (iss < ROWS_X);
    assign storing   = (state_q == LOAD) && wr_valid;
    assign wall_addr = issuing ? iss[ADDR_W-1:0] : '0;
    assign eat_ok    = (state_q == READY) && eat_valid &&
                       ({1'b0, eat_row} < ROWS_X) && mem[eat_row][eat_col];
    assign ready     = (state_q == READY);
    assign all_eaten = ready && (pellets_left == '0);

    for (genvar g = 0; g < NRD; g++) begin : g_rd_row
        assign rd_row[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Pellets contributed by the incoming wall row: every non-wall tile.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch or loop, otherwise a latch is inferred.
        wall_cnt = '0;
        for (int i = 0; i < COLS; i++)
            wall_cnt = wall_cnt + CNT_W'(wall_data[i]);
        row_pellets = CNT_W'(COLS) - wall_cnt;
    end

    always_comb begin
        state_d = state_q;
        if (restart)
            state_d = LOAD;
        else if (storing && wr == LAST_ROW)
            state_d = READY;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            iss          <= '0;
            wr           <= '0;
            wr_valid     <= 1'b0;
            eat_hit      <= 1'b0;
            pellets_left <= '0;
        end else begin
            eat_hit  <= eat_ok;
            wr_valid <= issuing;
            wr       <= iss[ADDR_W-1:0];
            if (issuing)
                iss <= iss + 1'b1;
            if (storing)
                pellets_left <= pellets_left + row_pellets;
            else if (eat_ok)
                pellets_left <= pellets_left - 1'b1;
        end
    end

    // NOTE: the map array has no reset; every row is rewritten by the load that reset/restart starts.
    always_ff @(posedge clk) begin
        if (!reset && !restart) begin
            if (storing)
                mem[wr] <= ~wall_data;
            if (eat_ok)
                mem[eat_row][eat_col] <= 1'b0;
        end
    end

    // Reads sample the array before this edge's update, so a colliding eat shows next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NRD; i++)
                rd_data[i*COLS +: COLS] <= ({1'b0, rd_row[i]} < ROWS_X) ? mem[rd_row[i]] : '0;
        end
    end

endmodule

// File: tb/tb_pellet_map_ram.sv
// Self-checking bench for pellet_map_ram: load, eats, read collisions, restart,
// level clear and reset during READY, with expected results queued at stimulus time.
module tb_pellet_map_ram;

    localparam int COLS = 32, ROWS = 24, ADDR_W = 5, NRD = 2, CNT_W = 10;
    localparam logic [31:0] ROW4_WALL = 32'hFC01803F;
    localparam logic [31:0] ROW4_FULL = 32'h03FE7FC0;

    logic                   clk, reset, restart;
    logic [ADDR_W-1:0]      wall_addr;
    logic [COLS-1:0]        wall_data;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD*COLS-1:0]    rd_data;
    logic                   eat_valid;
    logic [ADDR_W-1:0]      eat_row;
    logic [4:0]             eat_col;
    logic                   eat_hit;
    logic [CNT_W-1:0]       pellets_left;
    logic                   ready, all_eaten;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pellet_map_ram #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .NRD(NRD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .wall_addr(wall_addr), .wall_data(wall_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col),
        .eat_hit(eat_hit), .pellets_left(pellets_left),
        .ready(ready), .all_eaten(all_eaten)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall ROM stub with one-cycle registered read.
    initial wall_data = '1;
    always @(posedge clk)
        wall_data <= (wall_addr == 5'd4) ? ROW4_WALL : '1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (ready !== 1'b0)        begin errors++; $display("FAIL reset_ready: got %0b want 0", ready); end
        checks++; if (pellets_left !== '0)   begin errors++; $display("FAIL reset_pellets: got %0d want 0", pellets_left); end
        checks++; if (rd_data !== '0)        begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (eat_hit !== 1'b0 || all_eaten !== 1'b0 || wall_addr !== '0)
            begin errors++; $display("FAIL reset_misc: eat_hit %0b all_eaten %0b wall_addr %0d want 0/0/0", eat_hit, all_eaten, wall_addr); end
    endtask

    task automatic test_load();
        int n = 0;
        int bad_addr = 0;
        while (!ready && n < 100) begin
            if (wall_addr !== ((n < ROWS) ? 5'(n) : 5'd0)) bad_addr++;
            tick();
            n++;
        end
        checks++; if (n != 25)      begin errors++; $display("FAIL load_latency: got %0d cycles want 25", n); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL load_wall_addr: %0d bad cycles want 0", bad_addr); end
        checks++; if (pellets_left !== 10'd18) begin errors++; $display("FAIL load_pellets: got %0d want 18", pellets_left); end
        set_rd(5'd4, 5'd0);
        sb.push_back('{"load_row4_p0", 64'(ROW4_FULL)});
        sb.push_back('{"load_row0_p1", 64'h0});
        tick();
        e = sb.pop_front(); checks++; if (64'(rd_data[31:0])  !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.exp); end
        e = sb.pop_front(); checks++; if (64'(rd_data[63:32]) !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.exp); end
        set_rd(5'd0, 5'd0);
        sb.push_back('{"load_row0_p0", 64'h0});
        tick();
        e = sb.pop_front(); checks++; if (64'(rd_data[31:0]) !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.exp); end
    endtask

    task automatic test_eat();
        // hit, repeat miss, wall-tile miss
        logic [4:0] cols[3] = '{5'd6, 5'd6, 5'd0};
        logic       hits[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            eat_valid = 1'b1; eat_row = 5'd4; eat_col = cols[i];
            sb.push_back('{$sformatf("eat_hit_%0d", i), 64'(hits[i])});
            sb.push_back('{$sformatf("eat_count_%0d", i), 64'd17});
            tick();
            eat_valid = 1'b0;
            e = sb.pop_front(); checks++; if (64'(eat_hit) !== e.exp)      begin errors++; $display("FAIL %s: got %0d want %0d", e.name, eat_hit, e.exp); end
            e = sb.pop_front(); checks++; if (64'(pellets_left) !== e.exp) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, pellets_left, e.exp); end
        end
        set_rd(5'd4, 5'd0);
        sb.push_back('{"eat_row4_read", 64'h03FE7F80});
        tick();
        e = sb.pop_front(); checks++; if (64'(rd_data[31:0]) !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.exp); end
    endtask

    task automatic test_collision();
        set_rd(5'd4, 5'd30);
        eat_valid = 1'b1; eat_row = 5'd4; eat_col = 5'd7;
        sb.push_back('{"coll_p0_pre", 64'h03FE7F80});
        sb.push_back('{"coll_p1_oob", 64'h0});
        sb.push_back('{"coll_hit", 64'd1});
        tick();
        eat_valid = 1'b0;
        e = sb.pop_front(); checks++; if (64'(rd_data[31:0])  !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.exp); end
        e = sb.pop_front(); checks++; if (64'(rd_data[63:32]) !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.exp); end
        e = sb.pop_front(); checks++; if (64'(eat_hit) !== e.exp)        begin errors++; $display("FAIL %s: got %0d want %0d", e.name, eat_hit, e.exp); end
        sb.push_back('{"coll_p0_post", 64'h03FE7F00});
        tick();
        e = sb.pop_front(); checks++; if (64'(rd_data[31:0]) !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.exp); end
        checks++; if (pellets_left !== 10'd16) begin errors++; $display("FAIL coll_count: got %0d want 16", pellets_left); end
    endtask

    task automatic test_restart_midload();
        int n = 0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (10) tick();
        checks++; if (wall_addr !== 5'd10) begin errors++; $display("FAIL rs_addr_c10: got %0d want 10", wall_addr); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (wall_addr !== 5'd0 || pellets_left !== '0 || ready !== 1'b0)
            begin errors++; $display("FAIL rs_cleared: addr %0d count %0d ready %0b want 0/0/0", wall_addr, pellets_left, ready); end
        while (!ready && n < 100) begin tick(); n++; end
        checks++; if (n != 25) begin errors++; $display("FAIL rs_latency: got %0d cycles want 25", n); end
        checks++; if (pellets_left !== 10'd18) begin errors++; $display("FAIL rs_pellets: got %0d want 18", pellets_left); end
    endtask

    task automatic test_level_clear();
        int n = 0;
        int load_hits = 0;
        int early_clear = 0;
        int model_cnt = 18;
        logic [31:0] full = ROW4_FULL;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eat_valid = 1'b1; eat_row = 5'd4; eat_col = 5'(6 + i);
            tick();
            n++;
            if (eat_hit !== 1'b0) load_hits++;
        end
        eat_valid = 1'b0;
        while (!ready && n < 100) begin tick(); n++; end
        checks++; if (load_hits != 0) begin errors++; $display("FAIL lc_load_eats: %0d hits during load want 0", load_hits); end
        checks++; if (n != 25 || pellets_left !== 10'd18)
            begin errors++; $display("FAIL lc_reload: latency %0d count %0d want 25/18", n, pellets_left); end
        for (int c = 0; c < 32; c++) begin
            if (full[c]) begin
                eat_valid = 1'b1; eat_row = 5'd4; eat_col = 5'(c);
                model_cnt--;
                sb.push_back('{$sformatf("lc_hit_c%0d", c), 64'd1});
                sb.push_back('{$sformatf("lc_count_c%0d", c), 64'(model_cnt)});
                tick();
                e = sb.pop_front(); checks++; if (64'(eat_hit) !== e.exp)      begin errors++; $display("FAIL %s: got %0d want %0d", e.name, eat_hit, e.exp); end
                e = sb.pop_front(); checks++; if (64'(pellets_left) !== e.exp) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, pellets_left, e.exp); end
                if (model_cnt != 0 && all_eaten !== 1'b0) early_clear++;
            end
        end
        eat_valid = 1'b0;
        checks++; if (early_clear != 0) begin errors++; $display("FAIL lc_early_all_eaten: %0d cycles want 0", early_clear); end
        checks++; if (all_eaten !== 1'b1) begin errors++; $display("FAIL lc_all_eaten: got %0b want 1", all_eaten); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (all_eaten !== 1'b0) begin errors++; $display("FAIL lc_restart_clear: got %0b want 0", all_eaten); end
        n = 0;
        while (!ready && n < 100) begin tick(); n++; end
        checks++; if (pellets_left !== 10'd18) begin errors++; $display("FAIL lc_restart_count: got %0d want 18", pellets_left); end
    endtask

    task automatic test_reset_ready();
        int n = 0;
        set_rd(5'd4, 5'd4);
        tick();
        eat_valid = 1'b1; eat_row = 5'd4; eat_col = 5'd6;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        eat_valid = 1'b0;
        checks++; if (eat_hit !== 1'b0 || ready !== 1'b0)
            begin errors++; $display("FAIL rr_flags: eat_hit %0b ready %0b want 0/0", eat_hit, ready); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL rr_rd_data: got %h want 0", rd_data); end
        while (!ready && n < 100) begin tick(); n++; end
        checks++; if (n != 25 || pellets_left !== 10'd18)
            begin errors++; $display("FAIL rr_reload: latency %0d count %0d want 25/18", n, pellets_left); end
    endtask

    initial begin
        reset = 1'b0; restart = 1'b0; eat_valid = 1'b0;
        eat_row = '0; eat_col = '0; rd_addr = '0;
        #2;
        test_reset();
        test_load();
        test_eat();
        test_collision();
        test_restart_midload();
        test_level_clear();
        test_reset_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
